shift_right_serializer: RTL and testbench
=========================================

# shift_right_serializer

Parallel-in, serial-out right-shift unit: the transmitting end for the team's shift/concatenation datapath. It accepts a WIDTH-bit word through a valid/ready load handshake, then emits it LSB-first, one bit per accepted serial beat, with downstream backpressure. It optionally appends an even-parity bit and pulses `done` at the end of each word.

## Interface
- `WIDTH`, default 8: data word width; legal values are WIDTH ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `load_valid`  in  1: a parallel word is offered on `load_data`.
- `load_data`  in  WIDTH: word to serialize.
- `load_ready`  out  1: block can accept a word (high only in IDLE).
- `ser_out`  out  1: current serial bit.
- `ser_valid`  out  1: `ser_out` is meaningful.
- `ser_ready`  in  1: downstream consumes the current bit at this edge.
- `busy`  out  1: high in SHIFT, PARITY and DONE.
- `done`  out  1: one-cycle pulse after the last bit has been consumed.

## Operation
- Internal registers:
  - `state`: IDLE, SHIFT, PARITY, DONE.
  - `shreg[WIDTH-1:0]`: the shift register.
  - `cnt[$clog2(WIDTH)-1:0]`: bit counter.
  - `par`: parity register.
- **IDLE**
  - `load_ready`=1, `ser_valid`=0.
  - When `load_valid`&&`load_ready` at an edge: `shreg`<=`load_data`, `par`<=^`load_data`, `cnt`<=0, go to SHIFT.
- **SHIFT**
  - `ser_valid`=1, `ser_out`=`shreg[0]`.
  - On an edge with `ser_ready`=1: `shreg`<=`shreg`>>1 (zero fill), `cnt`<=`cnt`+1.
  - When `cnt`==WIDTH-1 and the beat is accepted: go to PARITY (macro defined) or DONE (macro undefined).
  - With `ser_ready`=0: `shreg`, `cnt` and `ser_out` hold.
- **PARITY**
  - `ser_valid`=1, `ser_out`=`par` (even parity, meaning the XOR of all data bits).
  - On `ser_ready`=1: go to DONE.
- **DONE**
  - `done`=1, `ser_valid`=0, `load_ready`=0.
  - Unconditionally go to IDLE on the next edge.
- Decoded outputs:
  - `load_ready`, `ser_valid`, `busy` and `done` are decoded from `state` only; no combinational path from any input to any output.
  - `ser_out`=0 whenever `ser_valid`=0.
- Load attempts outside IDLE are ignored. The block does not latch them, and `load_data` changes have no effect.
- Reset (async, any state, mid-word included):
  - `state`=IDLE, `shreg`=0, `cnt`=0, `par`=0.
  - Outputs settle to `load_ready`=1, `ser_valid`=0, `ser_out`=0, `busy`=0, `done`=0.
  - The partial word is discarded.
  - A load is never accepted while `rst_n`=0.

## Timing
- Load is accepted at edge E0; the first bit is valid in the cycle after E0.
- With `ser_ready` held high:
  - Bits occupy cycles 1..WIDTH; parity (if enabled) occupies cycle WIDTH+1.
  - `done` is high in the next cycle; the block is back in IDLE one cycle later.
  - Word period: WIDTH+2 cycles (no parity) or WIDTH+3 cycles (parity).
- Each cycle with `ser_ready`=0 while `ser_valid`=1 extends the word by exactly one cycle.
- `ser_valid`, once high, stays high until the final beat is accepted. The bit never changes while unaccepted.
- Back-to-back: with `load_valid` held high, the next word is accepted on the edge leaving the IDLE cycle that follows DONE.

## Configuration
- `SHIFT_RIGHT_PARITY_EN` defined:
  - PARITY state and `par` register are present.
  - Serial frame is WIDTH+1 bits: data LSB-first, then even parity.
- `SHIFT_RIGHT_PARITY_EN` undefined:
  - No PARITY state and no `par` register.
  - SHIFT goes directly to DONE; frame is WIDTH bits.
- All other behaviour is identical in both builds.

## Test plan
- WIDTH=8, load 8'hB5, `ser_ready`=1 -> `ser_out` 1,0,1,0,1,1,0,1 on cycles 1–8.
  - Parity build: then 1 on cycle 9, `done` on cycle 10.
  - Non-parity build: `done` on cycle 9.
- Backpressure: load 8'hB5, drop `ser_ready` for 3 cycles while bit 2 is presented -> `ser_out` holds 1 and `cnt` holds; the sequence resumes intact; `done` arrives 3 cycles later than without backpressure.
- Load while busy: pulse `load_valid` with 8'hFF during SHIFT -> ignored; the original word completes unchanged; `load_ready`=0 throughout.
- Async reset mid-word: assert `rst_n`=0 after bit 4 -> same cycle `ser_valid`=0, `busy`=0, `load_ready`=1; after release, a fresh load of 8'h0F emits 1,1,1,1,0,0,0,0 (parity 0).
- Back-to-back: `load_valid` held high with 8'h00 then 8'hFF -> 8'h00 gives all zeros (parity 0), 8'hFF gives all ones (parity 0); exactly one IDLE cycle separates the two words.
- Stall with parity pending (parity build): hold `ser_ready`=0 while the parity bit is presented -> `ser_out` is held and no `done` pulse occurs; `done` fires one cycle after the parity bit is accepted.

Source files
------------

// File: rtl/shift_right_serializer.sv
// rtl/shift_right_serializer.sv - LSB-first parallel-in/serial-out shifter with load and serial handshakes.
// Optional even-parity trailer bit is enabled by defining SHIFT_RIGHT_PARITY_EN.
module shift_right_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             last_bit;

`ifdef SHIFT_RIGHT_PARITY_EN
   logic             par;
`endif

   assign last_bit = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (load_valid) next_state = S_SHIFT;
         end
         S_SHIFT: begin
            if (ser_ready && last_bit) begin
`ifdef SHIFT_RIGHT_PARITY_EN
               next_state = S_PARITY;
`else
               next_state = S_DONE;
`endif
            end
         end
         S_PARITY: begin
            if (ser_ready) next_state = S_DONE;
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Datapath: loads only in IDLE, advances only on an accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         cnt   <= '0;
`ifdef SHIFT_RIGHT_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         if (state == S_IDLE && load_valid) begin
            shreg <= load_data;
            cnt   <= '0;
`ifdef SHIFT_RIGHT_PARITY_EN
            par   <= ^load_data;
`endif
         end else if (state == S_SHIFT && ser_ready) begin
            shreg <= shreg >> 1;
            cnt   <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      load_ready = 1'b0;
      ser_valid  = 1'b0;
      ser_out    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            load_ready = 1'b1;
         end
         S_SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = shreg[0];
            busy      = 1'b1;
         end
         S_PARITY: begin
            ser_valid = 1'b1;
`ifdef SHIFT_RIGHT_PARITY_EN
            ser_out   = par;
`endif
            busy      = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
            busy = 1'b1;
         end
         default: begin
            load_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_right_serializer.sv
// tb/tb_shift_right_serializer.sv - directed bench for shift_right_serializer (WIDTH=8).
// Honours SHIFT_RIGHT_PARITY_EN to match the build under test.
module tb_shift_right_serializer;

   localparam int W = 8;
`ifdef SHIFT_RIGHT_PARITY_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         load_valid = 1'b0;
   logic [W-1:0] load_data = '0;
   logic         load_ready;
   logic         ser_out;
   logic         ser_valid;
   logic         ser_ready = 1'b1;
   logic         busy;
   logic         done;

   int n_cmp = 0;
   int n_err = 0;

   shift_right_serializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .ser_ready  (ser_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input string what, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s.%s observed=%b expected=%b", tag, what, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check(tag, "load_ready", load_ready, 1'b1);
      check(tag, "ser_valid", ser_valid, 1'b0);
      check(tag, "ser_out", ser_out, 1'b0);
      check(tag, "busy", busy, 1'b0);
      check(tag, "done", done, 1'b0);
   endtask

   // Called at a falling edge while IDLE. mode 0: plain, 1: load pokes of FF during bits 2-3,
   // 2: keep load_valid high afterwards (back-to-back). stall_at < 0 disables backpressure.
   task automatic send(input string tag, input logic [7:0] w, input logic p,
                       input int stall_at, input int stall_len, input int mode);
      logic e;
      load_data  = w;
      load_valid = 1'b1;
      @(negedge clk);
      if (mode != 2) load_valid = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         e = (i < W) ? w[i] : p;
         if (i == stall_at) begin
            ser_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               check(tag, "stall_out", ser_out, e);
               check(tag, "stall_valid", ser_valid, 1'b1);
               check(tag, "stall_done", done, 1'b0);
               if (i < W) check(tag, "stall_cnt", dut.cnt == 3'(i), 1'b1);
               @(negedge clk);
            end
            ser_ready = 1'b1;
         end
         if (mode == 1) begin
            load_valid = (i == 2 || i == 3);
            load_data  = 8'hFF;
         end
         check(tag, "bit_out", ser_out, e);
         check(tag, "bit_valid", ser_valid, 1'b1);
         check(tag, "bit_busy", busy, 1'b1);
         check(tag, "bit_load_ready", load_ready, 1'b0);
         check(tag, "bit_done", done, 1'b0);
         @(negedge clk);
      end
      if (mode == 1) load_valid = 1'b0;
      check(tag, "done", done, 1'b1);
      check(tag, "done_valid", ser_valid, 1'b0);
      check(tag, "done_out", ser_out, 1'b0);
      check(tag, "done_load_ready", load_ready, 1'b0);
      check(tag, "done_busy", busy, 1'b1);
      @(negedge clk);
      check_idle({tag, "_after"});
   endtask

   initial begin
      // Reset, with a load attempt held through it.
      load_valid = 1'b1;
      load_data  = 8'hA5;
      repeat (3) @(negedge clk);
      check_idle("reset");
      load_valid = 1'b0;
      rst_n      = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      send("b5", 8'hB5, 1'b1, -1, 0, 0);
      send("b5_stall", 8'hB5, 1'b1, 2, 3, 0);
      send("b5_busy_load", 8'hB5, 1'b1, -1, 0, 1);

      // Async reset after bit 4 has been accepted.
      load_data  = 8'hB5;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_reset", "pre_valid", ser_valid, 1'b1);
      check("mid_reset", "pre_out", ser_out, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_idle("mid_reset");
      load_valid = 1'b1;
      load_data  = 8'h33;
      @(negedge clk);
      check_idle("mid_reset_hold");
      load_valid = 1'b0;
      rst_n      = 1'b1;
      @(negedge clk);
      check_idle("mid_reset_release");
      send("fresh_0f", 8'h0F, 1'b0, -1, 0, 0);

      send("b2b_00", 8'h00, 1'b0, -1, 0, 2);
      send("b2b_ff", 8'hFF, 1'b0, -1, 0, 0);

`ifdef SHIFT_RIGHT_PARITY_EN
      send("parity_stall", 8'hB5, 1'b1, W, 2, 0);
`else
      send("last_bit_stall", 8'hB5, 1'b1, W - 1, 2, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
